ps2_dev_rxtx: RTL and testbench

Device-side PS/2 engine that emulates a keyboard or mouse toward a PS/2 host port. It is the opposite end of the host-side rx/tx pair. It generates the PS/2 clock itself, sends device-to-host frames, and detects and receives host-to-device request-to-send frames, including the acknowledge bit. It is used to build loopback and emulation rigs, so the host-side units can be exercised on-board without a real peripheral.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_dev_clkgen.sv | 44 ++++
 rtl/ps2_dev_rxtx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ps2_dev_rxtx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the device-side PS/2 engine: state encoding,
// frame geometry and odd-parity helpers.
package ps2_pkg;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN  = 11;
    // Cycles after releasing ps2c before the synchronised copy can read high again
    localparam int SYNC_GUARD = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HOLD     = 4'd1,
        ST_TX_HI    = 4'd2,
        ST_TX_LO    = 4'd3,
        ST_RTS_WAIT = 4'd4,
        ST_RX_HI    = 4'd5,
        ST_RX_LO    = 4'd6,
        ST_ACK_HI   = 4'd7,
        ST_ACK_LO   = 4'd8,
        ST_ACK_REL  = 4'd9
    } ps2_state_e;

    // Parity bit that makes data+parity carry an odd number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // True when {parity, data} carries an odd number of ones
    function automatic logic parity_ok(input logic [8:0] par_data);
        return ^par_data;
    endfunction

endpackage

// File: rtl/ps2_dev_clkgen.sv
// Half-period timer shared by the transmit and receive paths. The FSM asks
// for a restart and for the clock line to be held low on the next cycle;
// this block keeps the count and the registered clock-low enable, and
// flags the mid-phase and end-of-phase points.
module ps2_dev_clkgen #(
    parameter int HALF_CYC = 2500,
    parameter int TW       = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tmr_clr,
    input  logic          clk_low_d,
    output logic [TW-1:0] tmr_q,
    output logic          mid_hit,
    output logic          end_hit,
    output logic          clk_low_q
);

    logic [TW-1:0] tmr_d;

    // Restart the count on request, otherwise advance by one
    always_comb begin
        if (tmr_clr) begin
            tmr_d = {TW{1'b0}};
        end else begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    // Timer and clock-low enable registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q     <= {TW{1'b0}};
            clk_low_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            clk_low_q <= clk_low_d;
        end
    end

    assign mid_hit = (tmr_q == TW'(HALF_CYC / 2));
    assign end_hit = (tmr_q == TW'(HALF_CYC - 1));

endmodule

// File: rtl/ps2_dev_rxtx.sv
// Device-side PS/2 engine: generates the PS/2 clock, sends device frames,
// receives host request-to-send frames and drives the acknowledge bit.
module ps2_dev_rxtx
    import ps2_pkg::*;
#(
    parameter int HALF_CYC    = 2500,
    parameter int HOLDOFF_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_dev,
    input  logic [7:0] din,
    inout  wire        ps2d,
    inout  wire        ps2c,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       rx_err_tick,
    output logic       tx_done_tick,
    output logic       tx_abort_tick,
    output logic       busy
);

    localparam int TMR_MAX = (HALF_CYC > HOLDOFF_CYC) ? HALF_CYC : HOLDOFF_CYC;
    localparam int TW      = $clog2(TMR_MAX);

    ps2_state_e state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [7:0]  dout_q, dout_d;
    logic        d_low_q, d_low_d;
    logic        busy_q, busy_d;
    logic        rx_done_q, rx_done_d, rx_err_q, rx_err_d;
    logic        tx_done_q, tx_done_d, tx_abort_q, tx_abort_d;
    logic [1:0]  c_sync_q, d_sync_q;
    logic        c_s, d_s;
    logic        c_low_d, c_low_q, tmr_clr, mid_hit, end_hit;
    logic [TW-1:0] tmr_q;

    assign c_s = c_sync_q[1];
    assign d_s = d_sync_q[1];

    ps2_dev_clkgen #(.HALF_CYC(HALF_CYC), .TW(TW)) u_clkgen (
        .clk       (clk),
        .reset     (reset),
        .tmr_clr   (tmr_clr),
        .clk_low_d (c_low_d),
        .tmr_q     (tmr_q),
        .mid_hit   (mid_hit),
        .end_hit   (end_hit),
        .clk_low_q (c_low_q)
    );

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        dout_d     = dout_q;
        d_low_d    = d_low_q;
        c_low_d    = 1'b0;
        tmr_clr    = 1'b0;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;
        tx_done_d  = 1'b0;
        tx_abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                d_low_d = 1'b0;
                if (!c_s) begin
                    // host request wins; a coincident wr_dev is dropped
                    state_d = ST_RTS_WAIT;
                end else if (wr_dev) begin
                    shreg_d  = {1'b1, odd_parity(din), din, 1'b0};
                    bitcnt_d = 4'd0;
                    state_d  = ST_TX_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TX_HI: begin
                if (mid_hit) begin
                    d_low_d = ~shreg_q[0];
                end else begin
                    d_low_d = d_low_q;
                end
                if (end_hit) begin
                    tmr_clr = 1'b1;
                    if (!c_s && (bitcnt_q < 4'd10)) begin
                        tx_abort_d = 1'b1;
                        d_low_d    = 1'b0;
                        state_d    = ST_RTS_WAIT;
                    end else begin
                        c_low_d = 1'b1;
                        state_d = ST_TX_LO;
                    end
                end else begin
                    state_d = ST_TX_HI;
                end
            end
            ST_TX_LO: begin
                if (end_hit) begin
                    tmr_clr  = 1'b1;
                    shreg_d  = {1'b0, shreg_q[FRAME_LEN-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd10) begin
                        d_low_d   = 1'b0;
                        tx_done_d = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d = ST_TX_HI;
                    end
                end else begin
                    c_low_d = 1'b1;
                end
            end
            ST_HOLD: begin
                d_low_d = 1'b0;
                if (!c_s || !d_s) begin
                    tmr_clr = 1'b1;
                end else if (tmr_q == TW'(HOLDOFF_CYC - 1)) begin
                    tmr_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RTS_WAIT: begin
                tmr_clr = 1'b1;
                d_low_d = 1'b0;
                if (c_s) begin
                    if (!d_s) begin
                        bitcnt_d = 4'd0;
                        state_d  = ST_RX_HI;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_RTS_WAIT;
                end
            end
            ST_RX_HI: begin
                // bitcnt counts clock pulses issued; samples follow pulses 1..10
                if ((tmr_q >= TW'(SYNC_GUARD)) && !c_s) begin
                    rx_err_d = 1'b1;
                    tmr_clr  = 1'b1;
                    state_d  = ST_RTS_WAIT;
                end else if (mid_hit && (bitcnt_q != 4'd0)) begin
                    shreg_d = {d_s, shreg_q[FRAME_LEN-1:1]};
                    if (bitcnt_q == 4'd10) begin
                        tmr_clr = 1'b1;
                        if (d_s) begin
                            state_d = ST_ACK_HI;
                        end else begin
                            rx_err_d = 1'b1;
                            state_d  = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_RX_HI;
                    end
                end else if (end_hit) begin
                    tmr_clr = 1'b1;
                    c_low_d = 1'b1;
                    state_d = ST_RX_LO;
                end else begin
                    state_d = ST_RX_HI;
                end
            end
            ST_RX_LO: begin
                if (end_hit) begin
                    tmr_clr  = 1'b1;
                    bitcnt_d = bitcnt_q + 4'd1;
                    state_d  = ST_RX_HI;
                end else begin
                    c_low_d = 1'b1;
                end
            end
            ST_ACK_HI: begin
                if (mid_hit) begin
                    d_low_d = 1'b1;
                end else begin
                    d_low_d = d_low_q;
                end
                if (end_hit) begin
                    tmr_clr = 1'b1;
                    c_low_d = 1'b1;
                    state_d = ST_ACK_LO;
                end else begin
                    state_d = ST_ACK_HI;
                end
            end
            ST_ACK_LO: begin
                if (end_hit) begin
                    tmr_clr = 1'b1;
                    state_d = ST_ACK_REL;
                end else begin
                    c_low_d = 1'b1;
                end
            end
            ST_ACK_REL: begin
                if (mid_hit) begin
                    tmr_clr = 1'b1;
                    d_low_d = 1'b0;
                    state_d = ST_HOLD;
                    if (parity_ok(shreg_q[9:1])) begin
                        dout_d    = shreg_q[8:1];
                        rx_done_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ACK_REL;
                end
            end
            default: begin
                d_low_d = 1'b0;
                tmr_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath, synchronisers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 4'd0;
            shreg_q    <= {FRAME_LEN{1'b0}};
            dout_q     <= 8'd0;
            d_low_q    <= 1'b0;
            busy_q     <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_abort_q <= 1'b0;
            c_sync_q   <= 2'b11;
            d_sync_q   <= 2'b11;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            d_low_q    <= d_low_d;
            busy_q     <= busy_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
            tx_done_q  <= tx_done_d;
            tx_abort_q <= tx_abort_d;
            c_sync_q   <= {c_sync_q[0], ps2c};
            d_sync_q   <= {d_sync_q[0], ps2d};
        end
    end

    assign ps2c          = c_low_q ? 1'b0 : 1'bz;
    assign ps2d          = d_low_q ? 1'b0 : 1'bz;
    assign dout          = dout_q;
    assign busy          = busy_q;
    assign rx_done_tick  = rx_done_q;
    assign rx_err_tick   = rx_err_q;
    assign tx_done_tick  = tx_done_q;
    assign tx_abort_tick = tx_abort_q;

endmodule

// File: tb/tb_ps2_dev_rxtx.sv
// Directed bench for ps2_dev_rxtx: a host model on the open-collector lines
// decodes device frames, sends host frames and checks tick behaviour.
module tb_ps2_dev_rxtx;

    localparam int HALF = 8;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_dev = 1'b0;
    logic [7:0] din = 8'h00;
    logic       host_c_low = 1'b0;
    logic       host_d_low = 1'b0;
    wire        ps2c;
    wire        ps2d;
    logic [7:0] dout;
    logic       rx_done_tick, rx_err_tick, tx_done_tick, tx_abort_tick, busy;

    assign ps2c = host_c_low ? 1'b0 : 1'bz;
    assign ps2d = host_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_dev_rxtx #(.HALF_CYC(HALF), .HOLDOFF_CYC(HOLD)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_dev        (wr_dev),
        .din           (din),
        .ps2d          (ps2d),
        .ps2c          (ps2c),
        .dout          (dout),
        .rx_done_tick  (rx_done_tick),
        .rx_err_tick   (rx_err_tick),
        .tx_done_tick  (tx_done_tick),
        .tx_abort_tick (tx_abort_tick),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_rx_done = 0, n_rx_err = 0, n_tx_done = 0, n_tx_abort = 0, n_overlap = 0;
    int tx_done_cyc = 0;

    // Tick counters, sampled away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_done_tick === 1'b1) n_rx_done = n_rx_done + 1;
        if (rx_err_tick === 1'b1) n_rx_err = n_rx_err + 1;
        if (tx_done_tick === 1'b1) begin
            n_tx_done = n_tx_done + 1;
            tx_done_cyc = cyc;
        end
        if (tx_abort_tick === 1'b1) n_tx_abort = n_tx_abort + 1;
        if ((int'(rx_done_tick) + int'(rx_err_tick) + int'(tx_done_tick) + int'(tx_abort_tick)) > 1)
            n_overlap = n_overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Wait for a ps2c edge (fall when want_fall=1, otherwise rise)
    task automatic wait_edge(input string tag, input bit want_fall);
        logic prev;
        bit   ok;
        ok = 1'b0;
        prev = ps2c;
        for (int i = 0; i < 8 * HALF; i++) begin
            tick();
            if (want_fall && prev === 1'b1 && ps2c === 1'b0) begin ok = 1'b1; break; end
            if (!want_fall && prev === 1'b0 && ps2c === 1'b1) begin ok = 1'b1; break; end
            prev = ps2c;
        end
        if (!ok) check({tag, "_edge_timeout"}, 32'd0, 32'd1);
    endtask

    // which: 0 rx_done, 1 rx_err, 2 tx_done, 3 tx_abort, 4 busy low
    task automatic wait_ev(input string tag, input int which, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            case (which)
                0: seen = (rx_done_tick === 1'b1);
                1: seen = (rx_err_tick === 1'b1);
                2: seen = (tx_done_tick === 1'b1);
                3: seen = (tx_abort_tick === 1'b1);
                default: seen = (busy === 1'b0);
            endcase
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // Host decodes one device frame, sampling data on each clock fall
    task automatic host_recv(input string tag, output logic [10:0] bits);
        bits = 11'd0;
        for (int k = 0; k < 11; k++) begin
            wait_edge(tag, 1'b1);
            bits[k] = ps2d;
        end
    endtask

    // Host request-to-send followed by 8 data, parity, stop; returns the ack level
    task automatic host_send(input string tag, input logic [7:0] data, input logic par, output logic ack);
        logic [9:0] frame;
        frame = {1'b1, par, data};
        host_c_low = 1'b1;
        repeat (40) tick();
        host_d_low = 1'b1;
        repeat (4) tick();
        host_c_low = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_edge(tag, 1'b1);
            host_d_low = ~frame[k];
        end
        wait_edge(tag, 1'b1);
        ack = ps2d;
        host_d_low = 1'b0;
    endtask

    logic [10:0] bits;
    logic        ack;
    int          c0, snap;
    logic [7:0]  b55;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // reset state
        reset = 1'b1;
        repeat (5) tick();
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ticks", {28'd0, rx_done_tick, rx_err_tick, tx_done_tick, tx_abort_tick}, 32'd0);
        check("rst_ps2c", {31'd0, ps2c}, 32'd1);
        check("rst_ps2d", {31'd0, ps2d}, 32'd1);
        reset = 1'b0;
        repeat (3) tick();

        // 1: device sends 0xA5 -> 0,1,0,1,0,0,1,0,1,parity 1,stop 1
        c0 = cyc;
        din = 8'hA5;
        wr_dev = 1'b1;
        tick();
        wr_dev = 1'b0;
        host_recv("t1", bits);
        check("t1_bits", {21'd0, bits}, {21'd0, 11'h74A});
        wait_ev("t1_txdone", 2, 4 * HALF);
        check("t1_lat", {31'd0, ((tx_done_cyc - c0) >= 22 * HALF) && ((tx_done_cyc - c0) <= 22 * HALF + 3)}, 32'd1);
        check("t1_busy_hold", {31'd0, busy}, 32'd1);
        wait_ev("t1_idle", 4, 4 * HOLD);
        check("t1_ntx", n_tx_done, 1);

        // 2: host sends 0xF4 with good parity 0
        host_send("t2", 8'hF4, 1'b0, ack);
        check("t2_ack", {31'd0, ack}, 32'd0);
        wait_ev("t2_rxdone", 0, 4 * HALF);
        check("t2_dout", {24'd0, dout}, 32'hF4);
        check("t2_ps2d_rel", {31'd0, ps2d}, 32'd1);
        wait_ev("t2_idle", 4, 4 * HOLD);
        check("t2_nrx", n_rx_done, 1);
        check("t2_nerr", n_rx_err, 0);

        // 3: host sends 0xF4 with bad parity 1, then 0x0F with bad parity 0
        host_send("t3", 8'hF4, 1'b1, ack);
        check("t3_ack", {31'd0, ack}, 32'd0);
        wait_ev("t3_rxerr", 1, 4 * HALF);
        wait_ev("t3_idle", 4, 4 * HOLD);
        host_send("t3b", 8'h0F, 1'b0, ack);
        check("t3b_ack", {31'd0, ack}, 32'd0);
        wait_ev("t3b_rxerr", 1, 4 * HALF);
        check("t3b_dout", {24'd0, dout}, 32'hF4);
        check("t3_nrx", n_rx_done, 1);
        check("t3_nerr", n_rx_err, 2);
        wait_ev("t3b_idle", 4, 4 * HOLD);

        // 4: host inhibits 0x12 in the high phase before the 5th device clock
        din = 8'h12;
        wr_dev = 1'b1;
        tick();
        wr_dev = 1'b0;
        for (int k = 0; k < 4; k++) wait_edge("t4", 1'b1);
        wait_edge("t4", 1'b0);
        host_c_low = 1'b1;
        wait_ev("t4_abort", 3, 2 * HALF);
        tick();
        check("t4_ps2d_rel", {31'd0, ps2d}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd1);
        repeat (10) tick();
        host_c_low = 1'b0;
        wait_ev("t4_idle", 4, 4 * HOLD);
        check("t4_ntx", n_tx_done, 1);
        check("t4_nabort", n_tx_abort, 1);
        check("t4_nerr", n_rx_err, 2);

        // 5: wr_dev in the same idle cycle as the synchronised clock-low
        host_c_low = 1'b1;
        tick();
        tick();
        din = 8'h3C;
        wr_dev = 1'b1;
        tick();
        wr_dev = 1'b0;
        host_send("t5", 8'h96, 1'b1, ack);
        check("t5_ack", {31'd0, ack}, 32'd0);
        wait_ev("t5_rxdone", 0, 4 * HALF);
        check("t5_dout", {24'd0, dout}, 32'h96);
        wait_ev("t5_idle", 4, 4 * HOLD);
        repeat (30) tick();
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_ntx", n_tx_done + n_tx_abort, 2);

        // 6: reset in the middle of a host frame, then a device send of 0x55
        snap = n_rx_done + n_rx_err + n_tx_done + n_tx_abort;
        b55 = 8'h55;
        host_c_low = 1'b1;
        repeat (40) tick();
        host_d_low = 1'b1;
        repeat (4) tick();
        host_c_low = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_edge("t6", 1'b1);
            host_d_low = ~b55[k];
        end
        tick();
        tick();
        check("t6_pre_ps2c", {31'd0, ps2c}, 32'd0);
        reset = 1'b1;
        host_d_low = 1'b0;
        tick();
        check("t6_rst_ps2c", {31'd0, ps2c}, 32'd1);
        check("t6_rst_ps2d", {31'd0, ps2d}, 32'd1);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        check("t6_noticks", n_rx_done + n_rx_err + n_tx_done + n_tx_abort, snap);
        din = 8'h55;
        wr_dev = 1'b1;
        tick();
        wr_dev = 1'b0;
        host_recv("t6", bits);
        check("t6_bits", {21'd0, bits}, {21'd0, 11'h6AA});
        wait_ev("t6_txdone", 2, 4 * HALF);
        check("t6_ntx", n_tx_done, 2);
        wait_ev("t6_idle", 4, 4 * HOLD);

        check("overlap", n_overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
